// File: rtl/bus_pkg.sv
// ============================================================================
// Module      : bus_pkg
// Description : Shared defaults, arbiter state type and address decode helper
//               for the bus_mxn shared-bus interconnect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam int BUS_AW        = 16;
    localparam int BUS_DW        = 64;
    localparam int BUS_REGION_AW = 12;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    // Region number of an address; callers compare it against the slave count.
    function automatic int unsigned slave_index(input logic [31:0] addr,
                                                input int unsigned region_aw);
        return addr >> region_aw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter with registered one-hot grant and a bounded
//               hold time while other requesters are waiting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_M    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM_M-1:0] i_req,
    output logic [NUM_M-1:0] o_grant
);

    localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int HW = $clog2(MAX_HOLD + 2);

    arb_state_t         r_state, w_state_nxt;
    logic [NUM_M-1:0]   r_grant, w_grant_nxt;
    logic [PW-1:0]      r_ptr, w_ptr_nxt;
    logic [HW-1:0]      r_hold, w_hold_nxt;

    logic [NUM_M-1:0]   w_cand;
    logic [2*NUM_M-1:0] w_dbl;
    logic               w_found;
    logic [PW-1:0]      w_off;
    logic [PW-1:0]      w_pick;
    int                 w_sum;
    logic               w_others;
    logic               w_hold_hit;
    logic               w_stay;

    // Candidate search rotated to start at the pointer; while owned the
    // owner is masked so it naturally ends up at lowest priority.
    always_comb begin
        w_cand  = (r_state == ST_OWNED) ? (i_req & ~r_grant) : i_req;
        w_dbl   = {w_cand, w_cand} >> r_ptr;
        w_found = 1'b0;
        w_off   = '0;
        for (int j = NUM_M - 1; j >= 0; j--) begin
            if (w_dbl[j]) begin
                w_found = 1'b1;
                w_off   = PW'(j);
            end
        end
        w_sum = int'(r_ptr) + int'(w_off);
        if (w_sum >= NUM_M) begin
            w_sum = w_sum - NUM_M;
        end
        w_pick = PW'(w_sum);
    end

    always_comb begin
        w_others   = |(i_req & ~r_grant);
        w_hold_hit = (MAX_HOLD != 0) && w_others && ((int'(r_hold) + 1) >= MAX_HOLD);
        w_stay     = (|(i_req & r_grant)) && !w_hold_hit;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt         = ST_OWNED;
                    w_grant_nxt         = '0;
                    w_grant_nxt[w_pick] = 1'b1;
                    w_ptr_nxt           = (int'(w_pick) == NUM_M - 1) ? '0 : w_pick + 1'b1;
                    w_hold_nxt          = '0;
                end
            end
            ST_OWNED: begin
                if (w_stay) begin
                    if (w_others && (MAX_HOLD != 0)) begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end else if (w_found) begin
                    w_grant_nxt         = '0;
                    w_grant_nxt[w_pick] = 1'b1;
                    w_ptr_nxt           = (int'(w_pick) == NUM_M - 1) ? '0 : w_pick + 1'b1;
                    w_hold_nxt          = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_hold_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    assign o_grant = r_grant;

endmodule

`default_nettype wire

// File: rtl/bus_mxn.sv
// ============================================================================
// Module      : bus_mxn
// Description : NUM_M x NUM_S shared-bus interconnect: arbitration, region
//               decode, forward mux and registered read-return path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_mxn
    import bus_pkg::*;
#(
    parameter int NUM_M     = 2,
    parameter int NUM_S     = 4,
    parameter int AW        = BUS_AW,
    parameter int DW        = BUS_DW,
    parameter int REGION_AW = BUS_REGION_AW,
    parameter int MAX_HOLD  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_M-1:0]    m_req,
    input  logic [NUM_M-1:0]    m_wr,
    input  logic [NUM_M*AW-1:0] m_addr,
    input  logic [NUM_M*DW-1:0] m_dout,
    output logic [NUM_M-1:0]    m_grant,
    output logic [DW-1:0]       m_din,
    output logic [NUM_M-1:0]    m_rvalid,
    output logic [NUM_M-1:0]    m_err,
    output logic [NUM_S-1:0]    s_sel,
    output logic [AW-1:0]       s_addr,
    output logic                s_wr,
    output logic [DW-1:0]       s_din,
    input  logic [NUM_S*DW-1:0] s_dout
);

    logic [NUM_M-1:0] w_grant;
    logic             w_access;
    logic             w_own_wr;
    logic [AW-1:0]    w_own_addr;
    logic [DW-1:0]    w_own_dout;
    int unsigned      w_sidx;
    logic             w_mapped;
    logic [DW-1:0]    w_slv_rdata;

    logic [NUM_M-1:0] r_rvalid;
    logic [NUM_M-1:0] r_err;
    logic [DW-1:0]    r_din;

    rr_arbiter #(
        .NUM_M    (NUM_M),
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req   (m_req),
        .o_grant (w_grant)
    );

    always_comb begin
        w_own_addr = '0;
        w_own_dout = '0;
        w_own_wr   = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (w_grant[i]) begin
                w_own_addr = m_addr[i*AW +: AW];
                w_own_dout = m_dout[i*DW +: DW];
                w_own_wr   = m_wr[i];
            end
        end
        w_access = |(w_grant & m_req);
        w_sidx   = slave_index(32'(w_own_addr), REGION_AW);
        w_mapped = (w_sidx < NUM_S);
    end

    always_comb begin
        s_sel       = '0;
        w_slv_rdata = '0;
        for (int k = 0; k < NUM_S; k++) begin
            if (w_sidx == k) begin
                s_sel[k]    = w_access && w_mapped;
                w_slv_rdata = s_dout[k*DW +: DW];
            end
        end
    end

    // Unmapped writes are dropped at the slave side but still reported.
    assign s_wr   = w_access && w_mapped && w_own_wr;
    assign s_addr = w_access ? w_own_addr : '0;
    assign s_din  = w_access ? w_own_dout : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid <= '0;
            r_err    <= '0;
            r_din    <= '0;
        end else begin
            r_rvalid <= '0;
            r_err    <= '0;
            if (w_access) begin
                if (!w_mapped) begin
                    r_err <= w_grant;
                    if (!w_own_wr) begin
                        r_din <= '0;
                    end
                end else if (!w_own_wr) begin
                    r_rvalid <= w_grant;
                    r_din    <= w_slv_rdata;
                end
            end
        end
    end

    assign m_grant  = w_grant;
    assign m_rvalid = r_rvalid;
    assign m_err    = r_err;
    assign m_din    = r_din;

endmodule

`default_nettype wire

// File: tb/tb_bus_mxn.sv
// ============================================================================
// Module      : tb_bus_mxn
// Description : Self-checking bench for bus_mxn with a queue-based scoreboard
//               and a behavioural arbitration/decode model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_mxn;

    localparam int NUM_M = 2;
    localparam int NUM_S = 4;
    localparam int AW    = 16;
    localparam int DW    = 64;
    localparam int RAW   = 12;
    localparam int MH    = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_M-1:0]    m_req;
    logic [NUM_M-1:0]    m_wr;
    logic [NUM_M*AW-1:0] m_addr;
    logic [NUM_M*DW-1:0] m_dout;
    logic [NUM_M-1:0]    m_grant;
    logic [DW-1:0]       m_din;
    logic [NUM_M-1:0]    m_rvalid;
    logic [NUM_M-1:0]    m_err;
    logic [NUM_S-1:0]    s_sel;
    logic [AW-1:0]       s_addr;
    logic                s_wr;
    logic [DW-1:0]       s_din;
    logic [NUM_S*DW-1:0] s_dout;

    bus_mxn #(
        .NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW),
        .REGION_AW(RAW), .MAX_HOLD(MH)
    ) dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr),
        .m_addr(m_addr), .m_dout(m_dout), .m_grant(m_grant), .m_din(m_din),
        .m_rvalid(m_rvalid), .m_err(m_err), .s_sel(s_sel), .s_addr(s_addr),
        .s_wr(s_wr), .s_din(s_din), .s_dout(s_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [NUM_M-1:0] rv;
        logic [NUM_M-1:0] er;
        logic [DW-1:0]    din;
        bit               keep;
    } ret_t;

    ret_t        sbq[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [DW-1:0] last_din = '0;

    // Reference arbitration state: current owner (-1 = none), first master
    // to consider when idle, and contended cycles spent by the owner.
    int m_owner = -1;
    int m_start = 0;
    int m_cont  = 0;

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int scan(int from, logic [NUM_M-1:0] r, int excl);
        for (int k = 0; k < NUM_M; k++) begin
            int j;
            j = (from + k) % NUM_M;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int nxt;
        bit others;
        if (reset) begin
            m_owner = -1; m_start = 0; m_cont = 0;
        end else if (m_owner < 0) begin
            nxt = scan(m_start, m_req, -1);
            if (nxt >= 0) begin
                m_owner = nxt; m_start = (nxt + 1) % NUM_M; m_cont = 0;
            end
        end else begin
            others = 0;
            for (int j = 0; j < NUM_M; j++) if (j != m_owner && m_req[j]) others = 1;
            if (others) m_cont++;
            if (!(m_req[m_owner] && !(MH > 0 && m_cont >= MH))) begin
                nxt = scan(m_owner + 1, m_req, m_owner);
                if (nxt >= 0) begin
                    m_owner = nxt; m_start = (nxt + 1) % NUM_M;
                end else begin
                    m_owner = -1;
                end
                m_cont = 0;
            end
        end
    endtask

    task automatic check_cycle();
        logic [NUM_M-1:0] eg;
        logic [NUM_S-1:0] esel;
        logic [AW-1:0]    a;
        logic [DW-1:0]    d;
        bit               acc, w, mapped;
        int               sidx;
        ret_t             it;
        eg = '0; esel = '0; a = '0; d = '0; w = 0; mapped = 0; sidx = 0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("grant", 256'(m_grant), 256'(eg));
        acc = (m_owner >= 0) && m_req[m_owner];
        if (acc) begin
            a      = m_addr[m_owner*AW +: AW];
            d      = m_dout[m_owner*DW +: DW];
            w      = m_wr[m_owner];
            sidx   = int'(a) / (1 << RAW);
            mapped = sidx < NUM_S;
            if (mapped) esel[sidx] = 1'b1;
        end
        chk("s_sel",  256'(s_sel),  256'(esel));
        chk("s_wr",   256'(s_wr),   256'(acc && mapped && w));
        chk("s_addr", 256'(s_addr), 256'(a));
        chk("s_din",  256'(s_din),  256'(acc ? d : '0));
        if (acc && !reset && (!mapped || !w)) begin
            it.due  = cyc + 1;
            it.rv   = mapped ? eg : '0;
            it.er   = mapped ? '0 : eg;
            it.din  = mapped ? s_dout[sidx*DW +: DW] : '0;
            it.keep = !mapped && w;
            sbq.push_back(it);
        end
        model_edge();
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(int i, bit rq, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
        m_req[i]           = rq;
        m_wr[i]            = w;
        m_addr[i*AW +: AW] = a;
        m_dout[i*DW +: DW] = d;
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset === 1'b1) last_din = '0;
    end

    // Read-return monitor: pops the scoreboard whenever the DUT responds.
    always @(negedge clk) begin
        ret_t e;
        if (m_rvalid != '0 || m_err != '0) begin
            n_assert++;
            if (sbq.size() == 0 || sbq[0].due != cyc) begin
                n_fail++;
                $display("FAIL unexpected_return: rvalid %0h err %0h din %0h, none expected (cycle %0d)",
                         m_rvalid, m_err, m_din, cyc);
            end else begin
                e = sbq.pop_front();
                if (e.keep) e.din = last_din;
                if (m_rvalid !== e.rv || m_err !== e.er || m_din !== e.din) begin
                    n_fail++;
                    $display("FAIL return: rvalid %0h err %0h din %0h expected rvalid %0h err %0h din %0h (cycle %0d)",
                             m_rvalid, m_err, m_din, e.rv, e.er, e.din, cyc);
                end
                last_din = e.din;
            end
        end else begin
            if (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                n_assert++;
                n_fail++;
                $display("FAIL missing_return: got none expected rvalid %0h err %0h (cycle %0d)",
                         e.rv, e.er, cyc);
            end
            chk("din_hold", 256'(m_din), 256'(last_din));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; m_req = '0; m_wr = '0; m_addr = '0; m_dout = '0; s_dout = '0;
        repeat (2) step();
        reset = 1'b0;
        #1;
        chk("rst_grant",  256'(m_grant),  256'(0));
        chk("rst_rvalid", 256'(m_rvalid), 256'(0));
        chk("rst_err",    256'(m_err),    256'(0));
        chk("rst_din",    256'(m_din),    256'(0));

        // Single-master write
        set_m(0, 1, 1, 16'h1056, 64'hABCD);
        step();
        #1;
        chk("wr_grant", 256'(m_grant), 256'(2'b01));
        chk("wr_sel",   256'(s_sel),   256'(4'b0010));
        chk("wr_swr",   256'(s_wr),    256'(1));
        chk("wr_sdin",  256'(s_din),   256'(64'hABCD));
        step();

        // Reads, then back-to-back reads of slaves 0 and 2
        set_m(0, 1, 0, 16'h0056, '0);
        s_dout[0*DW +: DW] = 64'h1111_FFFF;
        step();
        set_m(0, 1, 0, 16'h0100, '0);
        s_dout[0*DW +: DW] = 64'h2222;
        #1;
        chk("rd_din",    256'(m_din),    256'(64'h1111_FFFF));
        chk("rd_rvalid", 256'(m_rvalid), 256'(2'b01));
        step();
        set_m(0, 1, 0, 16'h2200, '0);
        s_dout[2*DW +: DW] = 64'h3333;
        #1;
        chk("b2b_din0", 256'(m_din), 256'(64'h2222));
        step();

        // Unmapped read then unmapped write
        set_m(0, 1, 0, 16'hFFEE, '0);
        #1;
        chk("b2b_din2", 256'(m_din), 256'(64'h3333));
        chk("unm_sel",  256'(s_sel), 256'(0));
        step();
        set_m(0, 1, 1, 16'hFFEE, 64'h55);
        #1;
        chk("unm_err",    256'(m_err),    256'(2'b01));
        chk("unm_rvalid", 256'(m_rvalid), 256'(0));
        chk("unm_din",    256'(m_din),    256'(0));
        chk("unm_wr",     256'(s_wr),     256'(0));
        step();
        m_req = '0;
        #1;
        chk("unm_werr", 256'(m_err), 256'(2'b01));
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Contention with hold limit
        set_m(0, 1, 0, 16'h0000, '0);
        set_m(1, 1, 0, 16'h1000, '0);
        step();
        for (int c = 0; c < MH; c++) begin
            #1;
            chk("hold_m0", 256'(m_grant), 256'(2'b01));
            step();
        end
        #1;
        chk("hold_switch", 256'(m_grant), 256'(2'b10));

        // Owner drop -> no gap, then rotation back to M0
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_req = 2'b11;
        step();
        #1;
        chk("cont_m0", 256'(m_grant), 256'(2'b01));
        m_req = 2'b10;
        step();
        #1;
        chk("nogap", 256'(m_grant), 256'(2'b10));
        m_req = 2'b00;
        step();
        #1;
        chk("idle", 256'(m_grant), 256'(2'b00));
        m_req = 2'b11;
        step();
        #1;
        chk("rotation", 256'(m_grant), 256'(2'b01));

        // Reset the cycle after a read access
        set_m(0, 1, 0, 16'h1000, '0);
        s_dout[1*DW +: DW] = 64'hBEEF;
        step();
        reset = 1'b1;
        #1;
        chk("pre_rst_rvalid", 256'(m_rvalid), 256'(2'b01));
        chk("pre_rst_din",    256'(m_din),    256'(64'hBEEF));
        step();
        reset = 1'b0;
        #1;
        chk("rst_mid_rvalid", 256'(m_rvalid), 256'(0));
        chk("rst_mid_grant",  256'(m_grant),  256'(0));
        step();
        #1;
        chk("post_rst_prio", 256'(m_grant), 256'(2'b01));

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NUM_M; i++) begin
                if ($urandom_range(0, 3) == 0) m_req[i] = ~m_req[i];
                m_wr[i]            = $urandom_range(0, 1) == 1;
                m_addr[i*AW +: AW] = AW'($urandom);
                m_dout[i*DW +: DW] = {$urandom, $urandom};
            end
            for (int k = 0; k < NUM_S; k++) s_dout[k*DW +: DW] = {$urandom, $urandom};
            step();
        end

        reset = 1'b0;
        m_req = '0;
        repeat (3) step();
        chk("sb_empty", 256'(sbq.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
